// File: rtl/adder_lin_pkg.sv
// Shared widths and types for the eight-operand linear adder.
// Stage widths are derived from the exact worst-case partial sum of each chain position.
package adder_lin_pkg;

  localparam int WIDTH   = 7;
  localparam int NUM_OPS = 8;
  localparam int SUM_W   = 10;
  localparam int OUT_W   = 8;

  typedef logic [WIDTH-1:0]                operand_t;
  typedef logic [NUM_OPS-1:0][WIDTH-1:0]   ops_t;

  // Bits needed for the partial sum after chain stage k (stage 0 adds two operands plus ci).
  function automatic int part_w(input int k);
    int max_val;
    max_val = (k + 2) * ((1 << WIDTH) - 1) + 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/adder_lin_stage.sv
// One ripple-carry adder stage of the linear chain: s_o = a_i + b_i + ci_i at S_W bits.
// S_W must be wide enough for the exact sum; the carry out of the top bit is never produced.
module adder_lin_stage #(
  parameter int A_W = 7,
  parameter int B_W = 7,
  parameter int S_W = 8
) (
  input  logic [A_W-1:0] a_i,
  input  logic [B_W-1:0] b_i,
  input  logic           ci_i,
  output logic [S_W-1:0] s_o
);

  logic [S_W-1:0] a_x;
  logic [S_W-1:0] b_x;

  assign a_x = S_W'(a_i);
  assign b_x = S_W'(b_i);

  always_comb begin
    logic carry;
    s_o   = '0;
    carry = ci_i;
    for (int i = 0; i < S_W; i++) begin
      s_o[i] = a_x[i] ^ b_x[i] ^ carry;
      carry  = (a_x[i] & b_x[i]) | (carry & (a_x[i] ^ b_x[i]));
    end
  end

endmodule

// File: rtl/adder_lin.sv
// Eight-operand linear adder with carry-in; registered {co,s} = total mod 256.
// Optional macro ADDER_LIN_OVF_EN adds a registered ovf output (total > 255).
module adder_lin
  import adder_lin_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] h,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef ADDER_LIN_OVF_EN
  ,
  output logic             ovf
`endif
);

  ops_t             ops;
  logic [SUM_W-1:0] part [NUM_OPS-1];
  logic [SUM_W-1:0] total;
  logic [OUT_W-1:0] res_d;
  logic [OUT_W-1:0] res_q;

  assign ops = {h, g, f, e, d, c, b, a};

  // Stage 0 is the only one that consumes the external carry-in.
  localparam int S0_W = part_w(0);
  logic [S0_W-1:0] sum0;

  adder_lin_stage #(.A_W(WIDTH), .B_W(WIDTH), .S_W(S0_W)) u_stage0 (
    .a_i  (ops[0]),
    .b_i  (ops[1]),
    .ci_i (ci),
    .s_o  (sum0)
  );

  assign part[0] = SUM_W'(sum0);

  for (genvar k = 1; k < NUM_OPS - 1; k++) begin : g_chain
    localparam int IN_W  = part_w(k - 1);
    localparam int OUT_SW = part_w(k);
    logic [OUT_SW-1:0] sum_k;

    adder_lin_stage #(.A_W(IN_W), .B_W(WIDTH), .S_W(OUT_SW)) u_stage (
      .a_i  (part[k-1][IN_W-1:0]),
      .b_i  (ops[k+1]),
      .ci_i (1'b0),
      .s_o  (sum_k)
    );

    assign part[k] = SUM_W'(sum_k);
  end

  assign total = part[NUM_OPS-2];
  assign res_d = total[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) res_q <= '0;
    else     res_q <= res_d;
  end

  assign s  = res_q[WIDTH-1:0];
  assign co = res_q[OUT_W-1];

`ifdef ADDER_LIN_OVF_EN
  logic ovf_d;
  logic ovf_q;

  assign ovf_d = |total[SUM_W-1:OUT_W];

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_adder_lin.sv
// Directed plus randomized checks of adder_lin against an integer-sum reference model.
module tb_adder_lin;
  import adder_lin_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] a, b, c, d, e, f, g, h;
  logic             ci;
  logic [WIDTH-1:0] s;
  logic             co;
`ifdef ADDER_LIN_OVF_EN
  logic             ovf;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  adder_lin dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .e   (e),
    .f   (f),
    .g   (g),
    .h   (h),
    .ci  (ci),
    .s   (s),
    .co  (co)
`ifdef ADDER_LIN_OVF_EN
    ,
    .ovf (ovf)
`endif
  );

  function automatic ops_t mk(input int v0, v1, v2, v3, v4, v5, v6, v7);
    ops_t r;
    r[0] = WIDTH'(v0); r[1] = WIDTH'(v1); r[2] = WIDTH'(v2); r[3] = WIDTH'(v3);
    r[4] = WIDTH'(v4); r[5] = WIDTH'(v5); r[6] = WIDTH'(v6); r[7] = WIDTH'(v7);
    return r;
  endfunction

  function automatic ops_t rand_ops();
    ops_t r;
    for (int i = 0; i < NUM_OPS; i++) r[i] = WIDTH'($urandom_range(0, 127));
    return r;
  endfunction

  // Drive one cycle of inputs, clock it, then compare against the arithmetic model.
  task automatic step(input ops_t ops, input logic vci, input logic vrst, input string tag);
    int             total;
    int             exp_s;
    int             exp_co;
    int             exp_ovf;
    {h, g, f, e, d, c, b, a} = ops;
    ci  = vci;
    rst = vrst;
    total = int'(vci);
    for (int i = 0; i < NUM_OPS; i++) total += int'(ops[i]);
    exp_s   = vrst ? 0 : (total % 256) % 128;
    exp_co  = vrst ? 0 : (total % 256) / 128;
    exp_ovf = (!vrst && total > 255) ? 1 : 0;
    @(posedge clk);
    #1;
    n_checks++;
    assert (int'(s) === exp_s) else begin
      n_fails++;
      $error("FAIL %s s: got %0d expected %0d (T=%0d)", tag, s, exp_s, total);
    end
    n_checks++;
    assert (int'(co) === exp_co) else begin
      n_fails++;
      $error("FAIL %s co: got %0d expected %0d (T=%0d)", tag, co, exp_co, total);
    end
`ifdef ADDER_LIN_OVF_EN
    n_checks++;
    assert (int'(ovf) === exp_ovf) else begin
      n_fails++;
      $error("FAIL %s ovf: got %0d expected %0d (T=%0d)", tag, ovf, exp_ovf, total);
    end
`else
    if (exp_ovf > 1) $display("unexpected model value");
`endif
  endtask

  initial begin
    rst = 1'b1;
    ci  = 1'b0;
    {h, g, f, e, d, c, b, a} = '0;

    step(rand_ops(), 1'b1, 1'b1, "reset0");
    step(rand_ops(), 1'b1, 1'b1, "reset1");
    step(mk(1, 1, 1, 1, 1, 1, 1, 1), 1'b0, 1'b0, "all_ones");
    step(mk(1, 2, 3, 4, 5, 6, 7, 8), 1'b0, 1'b0, "seq_ci0");
    step(mk(1, 2, 3, 4, 5, 6, 7, 8), 1'b1, 1'b0, "seq_ci1");
    step(mk(15, 15, 15, 15, 15, 15, 15, 15), 1'b0, 1'b0, "all15");
    step(mk(16, 15, 15, 15, 15, 15, 15, 15), 1'b1, 1'b0, "a16_ci1");
    step(mk(10, 14, 15, 0, 4, 6, 9, 13), 1'b0, 1'b0, "mixed");
    step(mk(16, 16, 16, 16, 16, 16, 16, 15), 1'b1, 1'b0, "t128");
    step(mk(127, 127, 127, 127, 127, 127, 127, 127), 1'b1, 1'b0, "t1017");
    step(mk(127, 127, 127, 127, 0, 0, 0, 0), 1'b0, 1'b0, "t508");
    step(mk(127, 127, 127, 127, 127, 127, 127, 127), 1'b1, 1'b1, "rst_prio");
    step(mk(3, 0, 0, 0, 0, 0, 0, 2), 1'b0, 1'b0, "post_rst_load");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, "zero");

    for (int i = 0; i < 300; i++) begin
      step(rand_ops(), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
